// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the PC, issues reads to the shared memory port, and buffers words for ID.
// Latency: 2 cycles from an accepted imem_req to id_valid. The pending slot is reserved at issue time.
// Backpressure: id_ready low holds the head and fetch runs until the queue is full. mem_busy/redirect block issue.
// Ports: clk/rst (sync, active-high); redirect_valid/redirect_pc from MEM; mem_busy;
//        imem_req/imem_addr/imem_rdata to the shared memory; id_valid/id_ready/id_instr/id_pc/id_pc_plus4 to IF/ID;
//        fetch_pc exposes the PC register.
module fetch_queue_unit #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        mem_busy,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] fetch_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;   // count spans 0..DEPTH
  localparam int OW = CW + 1;   // occupancy may reach DEPTH+1 before the compare

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pend_q, pend_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_instr_d [DEPTH];
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [31:0]   fifo_pc_d [DEPTH];

  logic          head_vld;
  logic          pop;
  logic          push;
  logic          issue;
  logic [OW-1:0] occupancy;

  assign head_vld = (count_q != '0);
  assign pop      = head_vld && id_ready;
  // The slot for the in-flight response is counted, so the queue never overflows.
  assign occupancy = OW'(count_q) + OW'(pend_q) - OW'(pop);
  assign issue     = !rst && !redirect_valid && !mem_busy && (occupancy < OW'(DEPTH));
  assign push      = pend_q && !redirect_valid;

  always_comb begin
    pc_d         = pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    pend_d       = 1'b0;
    pend_pc_d    = pend_pc_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    if (redirect_valid) begin
      // Flush queue and the in-flight response, and drop any pop this cycle.
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d      = pc_q + 32'd4;
        pend_d    = 1'b1;
        pend_pc_d = pc_q;
      end
      if (push) begin
        fifo_instr_d[wr_ptr_q] = imem_rdata;
        fifo_pc_d[wr_ptr_q]    = pend_pc_q;
        wr_ptr_d               = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC & 32'hFFFF_FFFC;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign fetch_pc    = pc_q;
  assign id_valid    = head_vld;
  assign id_instr    = head_vld ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
  assign id_pc       = head_vld ? fifo_pc_q[rd_ptr_q] : 32'h0;
  assign id_pc_plus4 = id_pc + 32'd4;

  no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && count_q == CW'(DEPTH)));
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Fetch stage front end for the pipelined RV32 core. It owns the program counter and issues instruction reads to the shared single-port instruction/data memory, yielding the port whenever the MEM stage is using it. Fetched words are buffered in a small FIFO that feeds the IF/ID register through a valid/ready handshake. A taken branch or jump from MEM redirects the PC and kills all queued and in-flight instructions.

Parameters:
DEPTH, 4, number of instruction queue entries (power of 2, 2..16)
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000033, word driven on id_instr while id_valid=0 (add x0,x0,x0)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
redirect_valid  in  1  taken branch/jump resolved in MEM this cycle
redirect_pc  in  32  redirect target
mem_busy  in  1  MEM stage owns the shared memory port this cycle (load/store)
imem_req  out  1  instruction read request this cycle
imem_addr  out  32  instruction read address (word aligned)
imem_rdata  in  32  read data, valid exactly 1 cycle after an accepted imem_req
id_ready  in  1  IF/ID can accept (low on load-use stall)
id_valid  out  1  queue head is valid
id_instr  out  32  queue head instruction, NOP_INSTR when id_valid=0
id_pc  out  32  PC of the head instruction
id_pc_plus4  out  32  id_pc + 4
fetch_pc  out  32  current fetch PC register

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- State: pc, FIFO of {instr, pc} (DEPTH entries, rd/wr pointers, count 0..DEPTH), pend (response expected next cycle), pend_pc.
- Reset: pc=RESET_PC, count=0, pointers=0, pend=0. Outputs during/after reset: imem_req=0 while rst=1, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=4, fetch_pc=RESET_PC.
- Issue (combinational): imem_req = !rst && !redirect_valid && !mem_busy && (count + pend - pop < DEPTH), where pop = id_valid && id_ready. imem_addr = pc.
- On issue: pc <= pc + 4 (mod 2^32, wraps 32'hFFFFFFFC -> 0), pend <= 1, pend_pc <= pc. Without issue: pend <= 0.
- Response: when pend=1 and no redirect this cycle, push {imem_rdata, pend_pc}. Latency is 2 cycles from issue to id_valid.
- Pop: when id_valid && id_ready, advance read pointer. Push and pop in the same cycle leave count unchanged. A push into an empty queue becomes visible the next cycle; there is no bypass.
- Overflow is impossible by construction. The issue condition reserves a slot for pend. A push when full is an assertion failure.
- Redirect (highest priority): pc <= {redirect_pc[31:2], 2'b00}, count <= 0, pointers <= 0, pend <= 0. The pending response and any pop that cycle are discarded, and no issue occurs. id_valid=0 on the next cycle. The first new instruction reaches id_valid 2 cycles after the first issue at the target.
- mem_busy high blocks issue only. Queued instructions continue draining to ID.
- id_ready low: the head is held stable (id_instr, id_pc unchanged) and fetch continues until the queue is full.
- Outputs id_* come from the FIFO head register and do not depend combinationally on id_ready.
- Reset asserted mid-operation overrides redirect and push. All state returns to reset values on that edge.

Test Plan:
- Reset then free-run with id_ready=1, mem_busy=0, memory word = address: id_valid rises in the 3rd cycle after rst falls. id_pc sequence is 0,4,8,... consecutively, with id_instr == id_pc and id_pc_plus4 == id_pc+4.
- id_ready=0 for 10 cycles: exactly DEPTH=4 issues occur, then imem_req=0. id_pc stays at its current head. Releasing id_ready delivers the 4 queued PCs in order with no gaps or duplicates.
- mem_busy=1 for cycles 5-7: no imem_req in those cycles. The output stream stays PC-contiguous and shows a bubble of at most 3 cycles.
- redirect_valid with redirect_pc=32'h00000103 while the queue holds 3 entries and one is pending: the next cycle has id_valid=0 and imem_addr=32'h00000100. The first delivered id_pc is 0x100, and no pre-redirect instruction appears.
- Wrap: start fetch at redirect_pc=32'hFFFFFFF8. Delivered PCs are FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- rst asserted for one cycle while the queue is full and redirect_valid=1: the next cycle has id_valid=0 and fetch_pc=RESET_PC, and the redirect is ignored.
